snake_input_sync: RTL and testbench



---
 rtl/snake_pkg.sv | 37 +++
 rtl/snake_input_sync_if.sv | 19 +
 rtl/snake_debounce.sv | 96 +++++++++
 rtl/snake_input_sync.sv | 81 ++++++++
 tb/tb_snake_input_sync.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared types and defaults for the snake front-end: direction codes, debounce
// state encoding and default timing constants.
package snake_pkg;

  localparam int STEP_CYCLES_DEF = 67108864;
  localparam int DB_CYCLES_DEF   = 1000000;
  localparam int CNT_W_DEF       = 27;

  localparam int NUM_KEYS = 3;
  localparam int NUM_SW   = 4;
  localparam int NUM_IN   = NUM_KEYS + NUM_SW;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PEND_ON,
    DB_ON,
    DB_PEND_OFF
  } db_state_e;

  // key2 dominates; key1 and key0 together cancel out to UP.
  function automatic dir_e dir_decode(input logic [NUM_KEYS-1:0] a);
    dir_e d;
    if (a[2])              d = DIR_LEFT;
    else if (a[1] && !a[0]) d = DIR_DOWN;
    else if (a[0] && !a[1]) d = DIR_RIGHT;
    else                   d = DIR_UP;
    return d;
  endfunction

endpackage

// File: rtl/snake_input_sync_if.sv
// Bus between the input conditioning stage and its neighbours. The pause
// signal exists only when SNAKE_PAUSE_EN is defined.
interface snake_input_sync_if;
  logic [2:0] button;
  logic [3:0] sw;
  logic       tick;
  logic [1:0] dir;
  logic [3:0] sw_lvl;
  logic [3:0] sw_rise;
`ifdef SNAKE_PAUSE_EN
  logic       pause;

  modport master (output button, sw, pause, input tick, dir, sw_lvl, sw_rise);
  modport slave  (input button, sw, pause, output tick, dir, sw_lvl, sw_rise);
`else
  modport master (output button, sw, input tick, dir, sw_lvl, sw_rise);
  modport slave  (input button, sw, output tick, dir, sw_lvl, sw_rise);
`endif
endinterface

// File: rtl/snake_debounce.sv
// One input conditioner: 2-flop synchroniser, then a 4-state debounce FSM whose
// level flips once the synchronised input has held a new value DB_CYCLES cycles.
module snake_debounce
  import snake_pkg::*;
#(
  parameter logic RELEASED_LVL = 1'b1,
  parameter int   DB_CYCLES    = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int               DB_W    = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            din;
  db_state_e       state, state_nxt;
  logic [DB_W-1:0] cnt, cnt_nxt;
  logic            level_nxt;

  assign din = sync_q[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {2{RELEASED_LVL}};
      state  <= DB_IDLE;
      cnt    <= '0;
      level  <= RELEASED_LVL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      level  <= level_nxt;
      rise   <= level_nxt & ~level;
      fall   <= ~level_nxt & level;
    end
  end

  // Entering a PEND state already counts the first differing cycle, so the
  // flip lands exactly DB_CYCLES cycles after the synchronised edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    case (state)
      DB_IDLE: begin
        if (din != RELEASED_LVL) begin
          state_nxt = DB_PEND_ON;
          cnt_nxt   = DB_W'(1);
        end
      end
      DB_PEND_ON: begin
        if (din == RELEASED_LVL) begin
          state_nxt = DB_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = DB_ON;
          cnt_nxt   = '0;
          level_nxt = ~RELEASED_LVL;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DB_ON: begin
        if (din == RELEASED_LVL) begin
          state_nxt = DB_PEND_OFF;
          cnt_nxt   = DB_W'(1);
        end
      end
      DB_PEND_OFF: begin
        if (din != RELEASED_LVL) begin
          state_nxt = DB_ON;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = DB_IDLE;
          cnt_nxt   = '0;
          level_nxt = RELEASED_LVL;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = DB_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/snake_input_sync.sv
// Snake front-end: debounces keys/switches, generates the game step tick and a
// step-aligned direction code. Define SNAKE_PAUSE_EN to add the pause input.
module snake_input_sync
  import snake_pkg::*;
#(
  parameter int STEP_CYCLES = STEP_CYCLES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst,
  snake_input_sync_if.slave bus
);

  // Keys rest high (active-low buttons), switches rest low.
  localparam logic [NUM_IN-1:0] RELEASED = {{NUM_SW{1'b0}}, {NUM_KEYS{1'b1}}};
  localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_CYCLES - 1);

  logic [NUM_IN-1:0]   raw, lvl, rise, fall;
  logic [CNT_W-1:0]    step_cnt;
  logic                run, wrap, tick;
  logic [NUM_KEYS-1:0] pend, key_act;
  dir_e                dir;
  logic                unused_db;

  assign raw = {bus.sw, bus.button};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_db
    snake_debounce #(
      .RELEASED_LVL (RELEASED[i]),
      .DB_CYCLES    (DB_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw[i]),
      .level (lvl[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  // Keys only care about press edges, switches only about rising edges.
  assign unused_db = ^{rise[NUM_KEYS-1:0], fall[NUM_IN-1:NUM_KEYS]};

`ifdef SNAKE_PAUSE_EN
  logic [1:0] pause_q;

  always_ff @(posedge clk) begin
    if (!rst) pause_q <= 2'b00;
    else      pause_q <= {pause_q[0], bus.pause};
  end

  assign run = ~pause_q[1];
`else
  assign run = 1'b1;
`endif

  assign wrap    = run && (step_cnt == STEP_LAST);
  assign key_act = pend | ~lvl[NUM_KEYS-1:0];

  // A press edge landing on the wrap cycle survives into the next step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      step_cnt <= '0;
      tick     <= 1'b0;
      dir      <= DIR_DOWN;
      pend     <= '0;
    end else begin
      if (run) step_cnt <= wrap ? '0 : step_cnt + 1'b1;
      tick <= wrap;
      if (wrap) dir <= dir_decode(key_act);
      pend <= (wrap ? '0 : pend) | fall[NUM_KEYS-1:0];
    end
  end

  assign bus.tick    = tick;
  assign bus.dir     = dir;
  assign bus.sw_lvl  = lvl[NUM_IN-1:NUM_KEYS];
  assign bus.sw_rise = rise[NUM_IN-1:NUM_KEYS];

endmodule

// File: tb/tb_snake_input_sync.sv
// Bench for snake_input_sync at STEP_CYCLES=16, DB_CYCLES=4: directed steps plus
// random key/switch traffic, every cycle compared against a behavioural model.
module tb_snake_input_sync;
  import snake_pkg::*;

  localparam int STEP = 16;
  localparam int DB   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  snake_input_sync_if bus ();

  snake_input_sync #(
    .STEP_CYCLES (STEP),
    .DB_CYCLES   (DB),
    .CNT_W       (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference state: raw delayed two cycles, debounced levels, the run length
  // of disagreement between delayed input and level, and the step phase.
  logic [6:0] m_s1, m_s2, m_lvl, m_rise, m_fall;
  int         m_run [7];
  int         m_ph;
  logic       m_tick;
  logic [1:0] m_dir;
  logic [2:0] m_pend;
`ifdef SNAKE_PAUSE_EN
  logic       m_p1, m_p2;
`endif

  function automatic logic [1:0] ref_dir(input logic [2:0] a);
    if (a[2])               return 2'b10;
    if (a[1] && !a[0])      return 2'b11;
    if (a[0] && !a[1])      return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_edge();
    logic [6:0] raw, nl;
    logic       tk, paused;
    raw = {bus.sw, bus.button};
    if (!rst) begin
      m_s1 = 7'b0000111; m_s2 = 7'b0000111; m_lvl = 7'b0000111;
      m_rise = '0; m_fall = '0;
      foreach (m_run[i]) m_run[i] = 0;
      m_ph = 0; m_tick = 1'b0; m_dir = 2'b11; m_pend = '0;
`ifdef SNAKE_PAUSE_EN
      m_p1 = 1'b0; m_p2 = 1'b0;
`endif
      return;
    end
`ifdef SNAKE_PAUSE_EN
    paused = m_p2;
`else
    paused = 1'b0;
`endif
    tk = !paused && (m_ph == STEP - 1);
    if (!paused) m_ph = (m_ph + 1) % STEP;
    if (tk) m_dir = ref_dir(m_pend | ~m_lvl[2:0]);
    m_pend = (tk ? 3'b000 : m_pend) | m_fall[2:0];
    m_tick = tk;
    nl = m_lvl;
    for (int i = 0; i < 7; i++) begin
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          nl[i] = ~m_lvl[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_rise = nl & ~m_lvl;
    m_fall = ~nl & m_lvl;
    m_lvl  = nl;
    m_s2 = m_s1;
    m_s1 = raw;
`ifdef SNAKE_PAUSE_EN
    m_p2 = m_p1;
    m_p1 = bus.pause;
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("tick",    32'(bus.tick),    32'(m_tick));
    chk("dir",     32'(bus.dir),     32'(m_dir));
    chk("sw_lvl",  32'(bus.sw_lvl),  32'(m_lvl[6:3]));
    chk("sw_rise", 32'(bus.sw_rise), 32'(m_rise[6:3]));
  endtask

  task automatic hold(input int k);
    repeat (k) step();
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.tick !== 1'b1 && n < 64);
    chk("tick_seen", 32'(bus.tick), 32'd1);
  endtask

  initial begin
    int n, ticks;
    bus.button = 3'b111;
    bus.sw     = 4'b0000;
`ifdef SNAKE_PAUSE_EN
    bus.pause  = 1'b0;
`endif
    rst = 1'b0;
    hold(3);
    chk("rst_dir",  32'(bus.dir),     32'h3);
    chk("rst_tick", 32'(bus.tick),    32'h0);
    chk("rst_lvl",  32'(bus.sw_lvl),  32'h0);
    chk("rst_rise", 32'(bus.sw_rise), 32'h0);

    rst = 1'b1;
    wait_tick(n);
    chk("first_tick_lat", n, 16);
    chk("first_dir", 32'(bus.dir), 32'h0);
    wait_tick(n);
    chk("tick_period", n, 16);
    step();
    chk("tick_one_cycle", 32'(bus.tick), 32'h0);

    // Bouncing key1 never settles long enough to register.
    wait_tick(n);
    for (int i = 0; i < 10; i++) begin
      bus.button[1] = i[0];
      hold(2);
    end
    bus.button[1] = 1'b1;
    wait_tick(n);
    chk("bounce_dir", 32'(bus.dir), 32'h0);
    wait_tick(n);
    chk("bounce_dir2", 32'(bus.dir), 32'h0);

    bus.button[1] = 1'b0;
    hold(8);
    bus.button[1] = 1'b1;
    wait_tick(n);
    chk("hold_key1", 32'(bus.dir), 32'h3);
    wait_tick(n);
    chk("hold_key1_after", 32'(bus.dir), 32'h0);

    // Short key0 press, released 6 cycles before the tick.
    hold(3);
    bus.button[0] = 1'b0;
    hold(7);
    bus.button[0] = 1'b1;
    wait_tick(n);
    chk("short_key0", 32'(bus.dir), 32'h1);
    wait_tick(n);
    chk("short_key0_after", 32'(bus.dir), 32'h0);

    bus.button = 3'b000;
    wait_tick(n);
    chk("prio_all", 32'(bus.dir), 32'h2);
    bus.button = 3'b100;
    wait_tick(n);
    chk("prio_k1k0", 32'(bus.dir), 32'h0);
    bus.button = 3'b111;
    wait_tick(n);
    wait_tick(n);

    // Switch rise latency and pulse width.
    bus.sw[2] = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.sw_lvl[2] !== 1'b1 && n < 20);
    chk("sw_lat", n, 6);
    chk("sw_rise_on", 32'(bus.sw_rise[2]), 32'h1);
    step();
    chk("sw_rise_off", 32'(bus.sw_rise[2]), 32'h0);
    bus.sw[1] = 1'b1;
    hold(3);
    bus.sw[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("sw_bounce_rise", 32'(bus.sw_rise[1]), 32'h0);
    end
    bus.sw[2] = 1'b0;
    hold(8);
    chk("sw_fall_lvl", 32'(bus.sw_lvl[2]), 32'h0);

    // Reset at counter==10 discards a pending key1 press.
    wait_tick(n);
    bus.button[1] = 1'b0;
    hold(8);
    bus.button[1] = 1'b1;
    hold(2);
    rst = 1'b0;
    step();
    rst = 1'b1;
    wait_tick(n);
    chk("rst_mid_lat", n, 16);
    chk("rst_mid_dir", 32'(bus.dir), 32'h0);

    for (int s = 0; s < 60; s++) begin
      bus.button = 3'($urandom_range(0, 7));
      bus.sw     = 4'($urandom_range(0, 15));
      hold($urandom_range(1, 20));
    end
    bus.button = 3'b111;
    bus.sw     = 4'b0000;
    hold(20);

`ifdef SNAKE_PAUSE_EN
    wait_tick(n);
    hold(3);
    bus.pause = 1'b1;
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5)  bus.button[1] = 1'b0;
      if (i == 13) bus.button[1] = 1'b1;
      step();
      if (bus.tick === 1'b1) ticks++;
    end
    chk("pause_ticks", ticks, 0);
    bus.pause = 1'b0;
    wait_tick(n);
    chk("pause_dir", 32'(bus.dir), 32'h3);
`else
    ticks = 0;
    chk("no_pause_ticks", ticks, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
